// File: rtl/shift_pkg.sv
// Shared types and mode decode helpers for the multi-cycle shift unit.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_CARRY_L = 3'b000,
        MODE_CARRY_R = 3'b001,
        MODE_CLEAR_L = 3'b010,
        MODE_CLEAR_R = 3'b011,
        MODE_PAR_L   = 3'b100,
        MODE_PAR_R   = 3'b101,
        MODE_RSVD_0  = 3'b110,
        MODE_RSVD_1  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FILL_CARRY  = 2'd0,
        FILL_ZERO   = 2'd1,
        FILL_PARITY = 2'd2
    } fill_e;

    function automatic logic is_left(input mode_e m);
        return ~m[0];
    endfunction

    function automatic logic is_reserved(input mode_e m);
        return m[2] & m[1];
    endfunction

    function automatic fill_e fill_sel(input mode_e m);
        fill_e f;
        case (m[2:1])
            2'b00:   f = FILL_CARRY;
            2'b10:   f = FILL_PARITY;
            default: f = FILL_ZERO;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step: one position left or right with mode-selected fill.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        case (fill_sel(mode_i))
            FILL_CARRY:  fill = carry_i;
            FILL_PARITY: fill = ^data_i;
            default:     fill = 1'b0;
        endcase

        if (is_left(mode_i)) begin
            carry_o = data_i[WIDTH-1];
            data_o  = {data_i[WIDTH-2:0], fill};
        end else begin
            carry_o = data_i[0];
            data_o  = {fill, data_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift unit with start/busy/done handshake.
// Define SHIFT_UNIT_FAST_EN to perform all steps in a single SHIFT cycle via an unrolled chain.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             parity
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    mode_e            mode_in;
    logic [CNT_W-1:0] amt_clamp;
    logic             carry_init;

    // Result of the work done in one SHIFT cycle, and whether it finishes the op.
    logic [WIDTH-1:0] sh_data;
    logic             sh_carry;
    logic [CNT_W-1:0] sh_cnt;
    logic             sh_last;

    assign mode_in    = mode_e'(mode);
    assign amt_clamp  = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;
    assign carry_init = (fill_sel(mode_in) == FILL_ZERO) ? 1'b0 : cin;

`ifdef SHIFT_UNIT_FAST_EN
    logic [WIDTH-1:0] ch_data  [WIDTH+1];
    logic             ch_carry [WIDTH+1];

    assign ch_data[0]  = data_q;
    assign ch_carry[0] = carry_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        logic [WIDTH-1:0] st_data;
        logic             st_carry;

        shift_step #(.WIDTH(WIDTH)) u_step (
            .data_i  (ch_data[i]),
            .carry_i (ch_carry[i]),
            .mode_i  (mode_q),
            .data_o  (st_data),
            .carry_o (st_carry)
        );

        // Stages beyond the requested count pass their input straight through.
        assign ch_data[i+1]  = (cnt_q > CNT_W'(i)) ? st_data  : ch_data[i];
        assign ch_carry[i+1] = (cnt_q > CNT_W'(i)) ? st_carry : ch_carry[i];
    end

    assign sh_data  = ch_data[WIDTH];
    assign sh_carry = ch_carry[WIDTH];
    assign sh_cnt   = '0;
    assign sh_last  = 1'b1;
`else
    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i  (data_q),
        .carry_i (carry_q),
        .mode_i  (mode_q),
        .data_o  (sh_data),
        .carry_o (sh_carry)
    );

    assign sh_cnt  = cnt_q - CNT_W'(1);
    assign sh_last = (cnt_q == CNT_W'(1));
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = din;
                    mode_d  = mode_in;
                    cnt_d   = amt_clamp;
                    carry_d = carry_init;
                    if (is_reserved(mode_in)) begin
                        dout_d  = din;
                        cout_d  = cin;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (amt_clamp == '0) begin
                        dout_d  = din;
                        cout_d  = carry_init;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d  = sh_data;
                carry_d = sh_carry;
                cnt_d   = sh_cnt;
                if (sh_last) begin
                    dout_d  = sh_data;
                    cout_d  = sh_carry;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_CARRY_L;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign dout   = dout_q;
    assign cout   = cout_q;
    assign parity = ^dout_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed table-driven bench for shift_unit (WIDTH=8), serial or SHIFT_UNIT_FAST_EN build.
module tb_shift_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [CNT_W-1:0] amt = '0;
    logic [WIDTH-1:0] din = '0;
    logic             cin = 1'b0;
    logic             busy, done, err, cout, parity;
    logic [WIDTH-1:0] dout;

    int errors = 0;
    int checks = 0;

    shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .amt    (amt),
        .din    (din),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .dout   (dout),
        .cout   (cout),
        .parity (parity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       mode;
        logic [7:0]       din;
        logic             cin;
        logic [CNT_W-1:0] amt;
        int               n;      // clamped shift count
        logic [7:0]       e_dout;
        logic             e_cout;
        logic             e_err;
        logic             e_par;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int n, input logic rsvd);
        if (n == 0 || rsvd) return 1;
`ifdef SHIFT_UNIT_FAST_EN
        return 2;
`else
        return n + 1;
`endif
    endfunction

    function automatic int exp_busy(input int n, input logic rsvd);
        if (n == 0 || rsvd) return 0;
`ifdef SHIFT_UNIT_FAST_EN
        return 1;
`else
        return n;
`endif
    endfunction

    // Accept at edge E0, then count cycles until done; lat is k where done is high in cycle E0+k.
    task automatic run_op(input vec_t v, input string tag);
        int k;
        int bcnt;
        logic rsvd;
        rsvd = v.mode[2] & v.mode[1];
        @(negedge clk);
        mode = v.mode; din = v.din; cin = v.cin; amt = v.amt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 1;
        bcnt = 0;
        while (!done && k < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " latency"}, k, exp_lat(v.n, rsvd));
        chk({tag, " busy_cycles"}, bcnt, exp_busy(v.n, rsvd));
        chk({tag, " dout"}, {24'd0, dout}, {24'd0, v.e_dout});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, v.e_cout});
        chk({tag, " err"}, {31'd0, err}, {31'd0, v.e_err});
        chk({tag, " parity"}, {31'd0, parity}, {31'd0, v.e_par});
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " dout_hold"}, {24'd0, dout}, {24'd0, v.e_dout});
    endtask

    initial begin
        vec_t v;
        int ndone;
        int first_k;

        //           mode    din    cin  amt  n  dout   cout  err   par
        vecs[0]  = '{3'b000, 8'h96, 1'b1, 4'd1,  1, 8'h2D, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b011, 8'h81, 1'b1, 4'd3,  3, 8'h10, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b100, 8'h07, 1'b0, 4'd2,  2, 8'h1E, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 8'hFF, 1'b1, 4'd12, 8, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b000, 8'hA5, 1'b1, 4'd0,  0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b110, 8'h3C, 1'b1, 4'd5,  5, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3'b001, 8'h01, 1'b0, 4'd1,  1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 8'h03, 1'b1, 4'd1,  1, 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'b000, 8'h80, 1'b0, 4'd8,  8, 8'h40, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b111, 8'h00, 1'b0, 4'd0,  0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b011, 8'hFF, 1'b1, 4'd0,  0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b100, 8'h01, 1'b1, 4'd9,  8, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 8'h55, 1'b0, 4'd15, 8, 8'h2A, 1'b1, 1'b0, 1'b1};

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset dout", {24'd0, dout}, 32'd0);
        chk("reset cout", {31'd0, cout}, 32'd0);
        chk("reset parity", {31'd0, parity}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse during SHIFT must be ignored: one done, first op's result.
        v = '{3'b000, 8'h01, 1'b0, 4'd5, 5, 8'h20, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        mode = v.mode; din = v.din; cin = v.cin; amt = v.amt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        first_k = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 1) begin
                @(negedge clk);
                mode = 3'b010; din = 8'hFF; amt = 4'd1; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                ndone++;
                if (first_k == 0) begin
                    first_k = k + 1;
                    chk("ignore dout", {24'd0, dout}, {24'd0, v.e_dout});
                    chk("ignore cout", {31'd0, cout}, {31'd0, v.e_cout});
                end
            end
        end
        chk("ignore done_count", ndone, 1);
        chk("ignore latency", first_k, exp_lat(5, 1'b0));

        // Reset mid-operation: outputs clear asynchronously and no done follows.
        v = '{3'b100, 8'h0F, 1'b1, 4'd6, 6, 8'h00, 1'b0, 1'b0, 1'b0};
        run_op(vecs[0], "pre_reset");
        @(negedge clk);
        mode = v.mode; din = v.din; cin = v.cin; amt = v.amt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort err", {31'd0, err}, 32'd0);
        chk("abort dout", {24'd0, dout}, 32'd0);
        chk("abort cout", {31'd0, cout}, 32'd0);
        chk("abort parity", {31'd0, parity}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no_activity", ndone, 0);

        // Unit must accept again normally after the abort.
        run_op(vecs[1], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
